if_id_hazard_reg: RTL and testbench

IF/ID pipeline register with integrated load-use hazard detection for the 5-stage MIPS pipeline. Captures the fetched PC and instruction each cycle, decodes register fields for the ID stage, and stalls on a load-use dependency against the instruction currently in EX. Holds its contents and freezes the PC during a stall, and commands a bubble into the ID/EX register. Flushes to a NOP on a taken branch and keeps a saturating stall-cycle counter for performance debug.

---
 rtl/if_id_hazard_reg.sv | 113 +++++++++++
 tb/tb_if_id_hazard_reg.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/if_id_hazard_reg.sv
// ---------------------------------------------------------------------------
// if_id_hazard_reg
//
// IF/ID pipeline register for the 5-stage MIPS pipeline with built-in
// load-use hazard detection.
//
// Behaviour:
//   - Captures the fetched PC+4 and instruction word on each rising edge.
//   - Holds both, and freezes the PC, when the instruction in ID depends on
//     a load that is currently in EX.
//   - Tells the ID/EX register to insert a bubble during that cycle.
//   - Flushes to a NOP on a taken branch or jump.
//   - Counts stall cycles for performance debug.
//
// Ports:
//   clk, rst      pipeline clock; asynchronous active-high reset
//   IfPc, IfInst  PC+4 and instruction word from the fetch stage
//   ExMemRead     MemRead bit of the instruction now in ID/EX
//   ExRt          rt field of the instruction now in ID/EX
//   BranchTaken   flush request from branch resolution in ID
//   IdPc, IdInst  registered PC+4 and instruction
//   IdRs/Rt/Rd    register fields decoded from IdInst
//   IdValid       registered instruction is real (not a reset/flush NOP)
//   Stall         combinational load-use hazard flag
//   PcWrite       PC write enable (the inverse of Stall)
//   IdBubble      zero the control fields written into ID/EX
//   StallCnt      saturating count of stall cycles
// ---------------------------------------------------------------------------
module if_id_hazard_reg #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      IfPc,
    input  logic [31:0]      IfInst,
    input  logic             ExMemRead,
    input  logic [4:0]       ExRt,
    input  logic             BranchTaken,
    output logic [31:0]      IdPc,
    output logic [31:0]      IdInst,
    output logic [4:0]       IdRs,
    output logic [4:0]       IdRt,
    output logic [4:0]       IdRd,
    output logic             IdValid,
    output logic             Stall,
    output logic             PcWrite,
    output logic             IdBubble,
    output logic [CNT_W-1:0] StallCnt
);

    logic [31:0]      id_pc_q,     id_pc_d;
    logic [31:0]      id_inst_q,   id_inst_d;
    logic             id_valid_q,  id_valid_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic [4:0] rs, rt;
    logic       stall;

    assign rs = id_inst_q[25:21];
    assign rt = id_inst_q[20:16];

    // A load writing $0 never produces a real dependency.
    // A flushed or reset NOP (IdValid = 0) has nothing to protect.
    assign stall = ExMemRead & id_valid_q & (ExRt != 5'd0) &
                   ((ExRt == rs) | (ExRt == rt));

    always_comb begin
        id_pc_d     = IfPc;
        id_inst_d   = IfInst;
        id_valid_d  = 1'b1;
        stall_cnt_d = stall_cnt_q;

        if (stall) begin
            // Hold the register. A branch resolved this cycle used stale
            // operands, so its flush request is dropped; it re-resolves
            // after the stall.
            id_pc_d    = id_pc_q;
            id_inst_d  = id_inst_q;
            id_valid_d = id_valid_q;
            if (stall_cnt_q != {CNT_W{1'b1}})
                stall_cnt_d = stall_cnt_q + 1'b1;
        end else if (BranchTaken) begin
            id_inst_d  = 32'h0;
            id_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_pc_q     <= '0;
            id_inst_q   <= '0;
            id_valid_q  <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            id_pc_q     <= id_pc_d;
            id_inst_q   <= id_inst_d;
            id_valid_q  <= id_valid_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign IdPc     = id_pc_q;
    assign IdInst   = id_inst_q;
    assign IdRs     = rs;
    assign IdRt     = rt;
    assign IdRd     = id_inst_q[15:11];
    assign IdValid  = id_valid_q;
    assign Stall    = stall;
    assign PcWrite  = ~stall;
    assign IdBubble = stall | ~id_valid_q;
    assign StallCnt = stall_cnt_q;

endmodule

// File: tb/tb_if_id_hazard_reg.sv
module tb_if_id_hazard_reg;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [31:0]      IfPc;
    logic [31:0]      IfInst;
    logic             ExMemRead;
    logic [4:0]       ExRt;
    logic             BranchTaken;
    logic [31:0]      IdPc;
    logic [31:0]      IdInst;
    logic [4:0]       IdRs;
    logic [4:0]       IdRt;
    logic [4:0]       IdRd;
    logic             IdValid;
    logic             Stall;
    logic             PcWrite;
    logic             IdBubble;
    logic [CNT_W-1:0] StallCnt;

    int total = 0;
    int bad   = 0;

    if_id_hazard_reg #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .IfPc(IfPc), .IfInst(IfInst),
        .ExMemRead(ExMemRead), .ExRt(ExRt), .BranchTaken(BranchTaken),
        .IdPc(IdPc), .IdInst(IdInst), .IdRs(IdRs), .IdRt(IdRt), .IdRd(IdRd),
        .IdValid(IdValid), .Stall(Stall), .PcWrite(PcWrite),
        .IdBubble(IdBubble), .StallCnt(StallCnt)
    );

    always #5 clk = ~clk;

    initial begin
        #20000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; IfPc = 32'h0; IfInst = 32'h0;
        ExMemRead = 1'b0; ExRt = 5'd0; BranchTaken = 1'b0;
        #12 rst = 1'b0;

        // Load a value, then reset asynchronously in mid-cycle.
        IfInst = 32'h012A4020; IfPc = 32'h100;
        step();
        chk("pre_rst_inst", IdInst, 32'h012A4020);
        chk("pre_rst_valid", {31'b0, IdValid}, 32'h1);
        #3 rst = 1'b1;
        #1;
        chk("rst_inst", IdInst, 32'h0);
        chk("rst_pc", IdPc, 32'h0);
        chk("rst_fields", {17'b0, IdRs, IdRt, IdRd}, 32'h0);
        chk("rst_valid", {31'b0, IdValid}, 32'h0);
        chk("rst_stall", {31'b0, Stall}, 32'h0);
        chk("rst_pcwrite", {31'b0, PcWrite}, 32'h1);
        chk("rst_bubble", {31'b0, IdBubble}, 32'h1);
        chk("rst_cnt", {28'b0, StallCnt}, 32'h0);
        #2 rst = 1'b0;
        IfInst = 32'h8C220004; IfPc = 32'h4;
        step();
        chk("cap_inst", IdInst, 32'h8C220004);
        chk("cap_rs", {27'b0, IdRs}, 32'd1);
        chk("cap_rt", {27'b0, IdRt}, 32'd2);
        chk("cap_valid", {31'b0, IdValid}, 32'h1);
        chk("cap_pc", IdPc, 32'h4);

        // Load-use hazard on rs: add $3,$2,$4 in ID, lw $2 in EX.
        IfInst = 32'h00441820; IfPc = 32'h200;
        step();
        ExMemRead = 1'b1; ExRt = 5'd2;
        IfInst = 32'h00A63820; IfPc = 32'h208;
        #1;
        chk("lu_stall", {31'b0, Stall}, 32'h1);
        chk("lu_pcwrite", {31'b0, PcWrite}, 32'h0);
        chk("lu_bubble", {31'b0, IdBubble}, 32'h1);
        step();
        chk("lu_hold_inst", IdInst, 32'h00441820);
        chk("lu_hold_pc", IdPc, 32'h200);
        chk("lu_cnt1", {28'b0, StallCnt}, 32'd1);
        ExMemRead = 1'b0;
        #1;
        chk("lu_release", {31'b0, Stall}, 32'h0);
        step();
        chk("lu_advance", IdInst, 32'h00A63820);
        chk("lu_cnt_kept", {28'b0, StallCnt}, 32'd1);

        // No hazard: a load to $0 matching the $0 fields of add $2,$0,$0.
        IfInst = 32'h00001020;
        step();
        ExMemRead = 1'b1; ExRt = 5'd0; IfInst = 32'h8C220004;
        #1;
        chk("nh_r0_stall", {31'b0, Stall}, 32'h0);
        step();
        chk("nh_r0_adv", IdInst, 32'h8C220004);
        // No hazard: ExRt matches IdRt but the EX instruction is not a load.
        ExMemRead = 1'b0; ExRt = 5'd2; IfInst = 32'h00441820;
        #1;
        chk("nh_nomr_stall", {31'b0, Stall}, 32'h0);
        chk("nh_nomr_bubble", {31'b0, IdBubble}, 32'h0);
        step();
        chk("nh_nomr_adv", IdInst, 32'h00441820);

        // Flush on a taken branch.
        BranchTaken = 1'b1; IfInst = 32'h012A4020; IfPc = 32'h300;
        step();
        chk("fl_inst", IdInst, 32'h0);
        chk("fl_valid", {31'b0, IdValid}, 32'h0);
        chk("fl_bubble", {31'b0, IdBubble}, 32'h1);
        chk("fl_pc", IdPc, 32'h300);
        BranchTaken = 1'b0;
        step();
        chk("fl_next", IdInst, 32'h012A4020);
        chk("fl_next_valid", {31'b0, IdValid}, 32'h1);

        // Stall together with a flush: the register holds and the flush is dropped.
        ExMemRead = 1'b1; ExRt = 5'd10; BranchTaken = 1'b1; IfInst = 32'hDEADBEEF;
        #1;
        chk("sf_stall", {31'b0, Stall}, 32'h1);
        step();
        chk("sf_hold", IdInst, 32'h012A4020);
        chk("sf_valid", {31'b0, IdValid}, 32'h1);
        chk("sf_cnt", {28'b0, StallCnt}, 32'd2);
        // Flush with a load to $0: there is no stall, so the flush applies.
        ExRt = 5'd0;
        #1;
        chk("f0_stall", {31'b0, Stall}, 32'h0);
        step();
        chk("f0_inst", IdInst, 32'h0);
        chk("f0_valid", {31'b0, IdValid}, 32'h0);

        // Counter saturation: 20 consecutive stall cycles on top of the count of 2.
        ExMemRead = 1'b0; BranchTaken = 1'b0; IfInst = 32'h012A4020;
        step();
        ExMemRead = 1'b1; ExRt = 5'd9;
        for (int i = 0; i < 20; i++) step();
        chk("sat_cnt", {28'b0, StallCnt}, 32'hF);
        chk("sat_still_stall", {31'b0, Stall}, 32'h1);
        chk("sat_hold", IdInst, 32'h012A4020);
        ExMemRead = 1'b0;
        step();
        chk("sat_no_wrap", {28'b0, StallCnt}, 32'hF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
